// File: rtl/imem_loader.sv
// Boot-time loader: holds the RV32 core in reset, streams program words into
// instruction memory over a valid/ready port, then releases the core.
module imem_loader #(
    parameter logic [31:0] BootVector = 32'h0000_0000,
    parameter int          MaxWords   = 1024,
    parameter bit          AutoRun    = 1'b0,
    localparam int         CntW       = $clog2(MaxWords) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_start,
    input  logic            load_base_sel,
    input  logic [31:0]     load_base,
    input  logic            s_valid,
    input  logic [31:0]     s_data,
    input  logic            s_last,
    output logic            s_ready,
    output logic            imem_we,
    output logic [31:0]     imem_addr,
    output logic [31:0]     imem_wdata,
    output logic            core_reset,
    output logic            busy,
    output logic            done,
    output logic            overflow,
    output logic [CntW-1:0] word_count
);

    typedef enum logic [1:0] {HOLD, LOAD, RELEASE, RUN} state_t;

    state_t            state_q;
    logic [31:0]       base_q;
    logic [CntW-1:0]   count_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              core_reset_q;
    logic              busy_q;
    logic              done_q;
    logic              overflow_q;

    logic              hs;
    logic              last_beat;
    logic [CntW-1:0]   count_d;
    logic [31:0]       addr_d;
    logic [31:0]       start_base;

    always_comb begin
        hs         = (state_q == LOAD) && s_valid;
        count_d    = count_q + 1'b1;
        // Address uses the pre-increment count; 32-bit add wraps silently.
        addr_d     = base_q + (32'(count_q) << 2);
        start_base = (load_base_sel ? load_base : BootVector) & 32'hFFFF_FFFC;
        last_beat  = hs && (s_last || (count_d == CntW'(MaxWords)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= AutoRun ? RUN : HOLD;
            base_q       <= 32'h0;
            count_q      <= '0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            core_reset_q <= !AutoRun;
            busy_q       <= 1'b0;
            done_q       <= AutoRun;
            overflow_q   <= 1'b0;
        end else begin
            we_q <= hs;
            if (hs) begin
                addr_q  <= addr_d;
                wdata_q <= s_data;
                count_q <= count_d;
            end
            case (state_q)
                HOLD, RUN: begin
                    if (load_start) begin
                        state_q      <= LOAD;
                        base_q       <= start_base;
                        count_q      <= '0;
                        overflow_q   <= 1'b0;
                        core_reset_q <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                    end
                end
                LOAD: begin
                    if (last_beat) begin
                        state_q <= RELEASE;
                        if (!s_last) overflow_q <= 1'b1;
                    end
                end
                RELEASE: begin
                    // Final write lands this cycle; core leaves reset next.
                    state_q      <= RUN;
                    core_reset_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                end
                default: state_q <= HOLD;
            endcase
        end
    end

    assign s_ready    = (state_q == LOAD);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign word_count = count_q;

endmodule
